apb_reg_slave: RTL

- APB3/APB4 completer (slave) register bank; sits on the APB side of the ahb2apb bridge and answers its PSEL/PENABLE transfers.
- Provides NUM_REGS 32-bit word registers, a programmable number of wait states, PSLVERR on illegal accesses, and byte strobes.
- Reg 0 is a read-only ID; all other registers are read/write.
- Also serves as the bench responder for bridge verification.

---
 rtl/apb_pkg.sv | 32 +++
 rtl/apb_wait_ctr.sv | 28 ++
 rtl/apb_reg_slave.sv | 139 +++++++++++++
 3 files changed

// File: rtl/apb_pkg.sv
// Shared types and the address decoder for the APB register slave.
// The decoder is a pure function so the slave and any checker agree on legality.
package apb_pkg;

   localparam int APB_DW = 32;
   localparam int APB_AW = 32;
   localparam int APB_SW = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DONE = 2'd2
   } apb_state_e;

   typedef struct packed {
      logic       legal;
      logic [7:0] idx;
   } apb_dec_t;

   // Legal means word aligned and inside the register window that starts at base.
   function automatic apb_dec_t apb_decode(input logic [APB_AW-1:0] addr,
                                           input logic [APB_AW-1:0] base,
                                           input int                nregs);
      logic [APB_AW-1:0] off;
      apb_dec_t          d;
      off     = addr - base;
      d.legal = (addr[1:0] == 2'b00) && (off < APB_AW'(nregs * 4));
      d.idx   = off[9:2];
      return d;
   endfunction

endpackage

// File: rtl/apb_wait_ctr.sv
// Loadable down-counter that flags the last wait cycle (count of one).
// Stops at zero so a stray decrement never wraps.
module apb_wait_ctr #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         dec,
   output logic         term
);

   logic [W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (dec && (cnt != '0)) begin
         cnt <= cnt - W'(1);
      end
   end

   assign term = (cnt == W'(1));

endmodule

// File: rtl/apb_reg_slave.sv
// APB3/APB4 completer: word register bank with read-only ID at reg 0,
// programmable wait states, byte strobes, PSLVERR and protocol-violation pulse.
module apb_reg_slave
   import apb_pkg::*;
#(
   parameter int          NUM_REGS    = 16,
   parameter int          WAIT_STATES = 1,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter logic [31:0] ID_VALUE    = 32'hA2B0_0001
) (
   input  logic              HCLK,
   input  logic              HRESET,
   input  logic              PSEL,
   input  logic              PENABLE,
   input  logic              PWRITE,
   input  logic [APB_AW-1:0] PADDR,
   input  logic [APB_DW-1:0] PWDATA,
   input  logic [APB_SW-1:0] PSTRB,
   output logic [APB_DW-1:0] PRDATA,
   output logic              PREADY,
   output logic              PSLVERR,
   output logic              proto_err
);

   localparam int IW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

   // Handshake: a transfer is a setup cycle (PSEL & !PENABLE) followed by access
   // cycles (PSEL & PENABLE); it completes on the edge where PREADY is also high.
   apb_state_e state_q, state_d;

   logic [APB_DW-1:0] regs [NUM_REGS];
   logic [APB_AW-1:0] lat_addr;
   logic [APB_DW-1:0] lat_wdata;
   logic [APB_SW-1:0] lat_strb;
   logic              lat_write;

   logic              setup, access, term;
   logic [APB_AW-1:0] cur_addr;
   logic              cur_write;
   apb_dec_t          cur_dec;
   logic [IW-1:0]     ridx;
   logic              acc_err;
   logic [APB_DW-1:0] rd_val;
   logic              load_out, commit;
   logic              pready_d, pslverr_d, perr_d;
   logic [APB_DW-1:0] prdata_d;

   assign setup  = PSEL && !PENABLE;
   assign access = PSEL && PENABLE;

   // With zero wait states the response is built in the setup cycle, before the latches fill.
   assign cur_addr  = (state_q == IDLE) ? PADDR  : lat_addr;
   assign cur_write = (state_q == IDLE) ? PWRITE : lat_write;
   assign cur_dec   = apb_decode(cur_addr, BASE_ADDR, NUM_REGS);
   assign ridx      = cur_dec.idx[IW-1:0];
   assign acc_err   = !cur_dec.legal || (cur_write && (cur_dec.idx == 8'd0))
                      || (|(cur_dec.idx >> IW));
   assign rd_val    = (cur_dec.idx == 8'd0) ? ID_VALUE : regs[ridx];

   apb_wait_ctr #(.W(4)) u_wait_ctr (
      .clk      (HCLK),
      .rst      (HRESET),
      .load     ((state_q == IDLE) && setup),
      .load_val (4'(WAIT_STATES)),
      .dec      (state_q == WAIT),
      .term     (term)
   );

   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (setup) state_d = (WAIT_STATES == 0) ? DONE : WAIT;
         WAIT: begin
            if (!access)   state_d = IDLE;
            else if (term) state_d = DONE;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      pready_d  = 1'b0;
      pslverr_d = 1'b0;
      prdata_d  = '0;
      load_out  = ((state_q == IDLE) && setup && (WAIT_STATES == 0)) ||
                  ((state_q == WAIT) && access && term);
      if (load_out) begin
         pready_d  = 1'b1;
         pslverr_d = acc_err;
         prdata_d  = (!cur_write && !acc_err) ? rd_val : '0;
      end
      perr_d = ((state_q == IDLE) && access) || ((state_q == WAIT) && !access);
      commit = (state_q == DONE) && lat_write && !PSLVERR;
   end

   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         PREADY    <= 1'b0;
         PSLVERR   <= 1'b0;
         PRDATA    <= '0;
         proto_err <= 1'b0;
         lat_addr  <= '0;
         lat_wdata <= '0;
         lat_strb  <= '0;
         lat_write <= 1'b0;
      end else begin
         PREADY    <= pready_d;
         PSLVERR   <= pslverr_d;
         PRDATA    <= prdata_d;
         proto_err <= perr_d;
         if ((state_q == IDLE) && setup) begin
            lat_addr  <= PADDR;
            lat_wdata <= PWDATA;
            lat_strb  <= PSTRB;
            lat_write <= PWRITE;
         end
      end
   end

   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      end else if (commit) begin
         for (int b = 0; b < APB_SW; b++) begin
            if (lat_strb[b]) regs[ridx][8*b +: 8] <= lat_wdata[8*b +: 8];
         end
      end
   end

endmodule
